// File: rtl/minsearch_pkg.sv
// rtl/minsearch_pkg.sv - shared types and default widths for the minimum-search path
package minsearch_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/minsearch_cmp.sv
// rtl/minsearch_cmp.sv - read-pipeline tracker, running-minimum compare and Load_Addr strobe
module minsearch_cmp
    import minsearch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              load_addr_o,
    output logic [ADDR_W-1:0] mux_addr_o,
    output logic [DATA_W-1:0] min_data_o
);

    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic              first_q;
    logic [DATA_W-1:0] min_q;
    logic              load;

    // The first word always loads, even when it equals the all-ones seed value.
    always_comb begin
        load = valid_q & (first_q | (rd_data_i < min_q));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            first_q <= 1'b0;
            min_q   <= '1;
        end else begin
            valid_q <= rd_en_i;
            addr_q  <= rd_addr_i;
            if (clear_i) begin
                first_q <= 1'b1;
                min_q   <= '1;
            end else if (load) begin
                first_q <= 1'b0;
                min_q   <= rd_data_i;
            end
        end
    end

    assign load_addr_o = load;
    assign mux_addr_o  = addr_q;
    assign min_data_o  = min_q;

endmodule

// File: rtl/min_search_ctrl.sv
// rtl/min_search_ctrl.sv - window sweep sequencer driving the minimum-address register
module min_search_ctrl
    import minsearch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              Clk,
    input  logic              Rst_N,
    input  logic              Start,
    input  logic [ADDR_W-1:0] Base_Addr,
    input  logic [ADDR_W:0]   Length,
    output logic              Mem_Rd_En,
    output logic [ADDR_W-1:0] Mem_Addr,
    input  logic [DATA_W-1:0] Mem_Rd_Data,
    output logic              Load_Addr,
    output logic [ADDR_W-1:0] Mux_Addr,
    output logic [DATA_W-1:0] Min_Data,
    output logic              Busy,
    output logic              Done
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              start_accept;

    always_ff @(posedge Clk) begin
        if (!Rst_N) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt_q holds the number of reads still to issue, including the current one.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        start_accept = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    start_accept = 1'b1;
                    addr_d       = Base_Addr;
                    cnt_d        = Length;
                    state_d      = (Length == '0) ? DONE : READ;
                end
            end
            READ: begin
                addr_d = addr_q + 1'b1;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == (ADDR_W + 1)'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Mem_Rd_En = (state_q == READ);
    assign Mem_Addr  = addr_q;
    assign Busy      = (state_q != IDLE);
    assign Done      = (state_q == DONE);

    minsearch_cmp #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_cmp (
        .clk_i       (Clk),
        .rst_ni      (Rst_N),
        .clear_i     (start_accept),
        .rd_en_i     (Mem_Rd_En),
        .rd_addr_i   (Mem_Addr),
        .rd_data_i   (Mem_Rd_Data),
        .load_addr_o (Load_Addr),
        .mux_addr_o  (Mux_Addr),
        .min_data_o  (Min_Data)
    );

endmodule

// File: tb/tb_min_search_ctrl.sv
// tb/tb_min_search_ctrl.sv - table-driven and randomized checks of min_search_ctrl
module tb_min_search_ctrl;

    logic       Clk;
    logic       Rst_N;
    logic       Start;
    logic [7:0] Base_Addr;
    logic [8:0] Length;
    logic       Mem_Rd_En;
    logic [7:0] Mem_Addr;
    logic [7:0] Mem_Rd_Data;
    logic       Load_Addr;
    logic [7:0] Mux_Addr;
    logic [7:0] Min_Data;
    logic       Busy;
    logic       Done;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:255];

    logic [7:0] got_rd [$];
    logic [7:0] got_ld [$];
    int         got_done [$];
    logic       got_busy [$];
    logic [7:0] got_min;
    logic [7:0] exp_rd [$];
    logic [7:0] exp_ld [$];
    logic [7:0] exp_min;
    int         exp_done;

    typedef struct {
        string      name;
        logic [7:0] base;
        int         len;
        logic [7:0] words [0:7];
        logic [7:0] load_mask;
        logic [7:0] min_val;
        int         done_cyc;
    } vec_t;

    vec_t vecs [5];

    min_search_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
        .Clk         (Clk),
        .Rst_N       (Rst_N),
        .Start       (Start),
        .Base_Addr   (Base_Addr),
        .Length      (Length),
        .Mem_Rd_En   (Mem_Rd_En),
        .Mem_Addr    (Mem_Addr),
        .Mem_Rd_Data (Mem_Rd_Data),
        .Load_Addr   (Load_Addr),
        .Mux_Addr    (Mux_Addr),
        .Min_Data    (Min_Data),
        .Busy        (Busy),
        .Done        (Done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (Mem_Rd_En) Mem_Rd_Data <= mem[Mem_Addr];
    end

    task automatic check(input bit ok, input string name, input int got, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    // Reference: every window word in order, a strictly smaller value (or the first word) loads.
    task automatic model(input logic [7:0] base, input int len);
        int cur;
        exp_rd.delete();
        exp_ld.delete();
        cur = 256;
        for (int i = 0; i < len; i++) begin
            logic [7:0] a;
            a = 8'((int'(base) + i) % 256);
            exp_rd.push_back(a);
            if (i == 0 || int'(mem[a]) < cur) begin
                exp_ld.push_back(a);
                cur = int'(mem[a]);
            end
        end
        exp_min  = (len == 0) ? 8'hFF : 8'(cur);
        exp_done = (len == 0) ? 1 : len + 2;
    endtask

    task automatic run(input logic [7:0] base, input int len, input int restart_cyc);
        got_rd.delete();
        got_ld.delete();
        got_done.delete();
        got_busy.delete();
        got_min = 8'h00;
        @(negedge Clk);
        Base_Addr = base;
        Length    = 9'(len);
        Start     = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        for (int c = 1; c <= len + 6; c++) begin
            @(negedge Clk);
            if (Mem_Rd_En) got_rd.push_back(Mem_Addr);
            if (Load_Addr) got_ld.push_back(Mux_Addr);
            if (Done) begin
                got_done.push_back(c);
                got_min = Min_Data;
            end
            got_busy.push_back(Busy);
            if (c == restart_cyc) Start = 1'b1;
            @(posedge Clk);
            #1 Start = 1'b0;
        end
    endtask

    task automatic compare(input string name);
        int bad_idx;
        bad_idx = -1;
        check(got_rd.size() == exp_rd.size(), {name, " rd_count"}, got_rd.size(), exp_rd.size());
        for (int i = 0; i < got_rd.size() && i < exp_rd.size(); i++)
            if (bad_idx < 0 && got_rd[i] !== exp_rd[i]) bad_idx = i;
        check(bad_idx < 0, {name, " rd_addr_seq"}, (bad_idx < 0) ? 0 : int'(got_rd[bad_idx]),
              (bad_idx < 0) ? 0 : int'(exp_rd[bad_idx]));
        bad_idx = -1;
        check(got_ld.size() == exp_ld.size(), {name, " load_count"}, got_ld.size(), exp_ld.size());
        for (int i = 0; i < got_ld.size() && i < exp_ld.size(); i++)
            if (bad_idx < 0 && got_ld[i] !== exp_ld[i]) bad_idx = i;
        check(bad_idx < 0, {name, " load_addr_seq"}, (bad_idx < 0) ? 0 : int'(got_ld[bad_idx]),
              (bad_idx < 0) ? 0 : int'(exp_ld[bad_idx]));
        check(got_done.size() == 1, {name, " done_count"}, got_done.size(), 1);
        check(got_done.size() > 0 && got_done[0] == exp_done, {name, " done_cycle"},
              (got_done.size() > 0) ? got_done[0] : -1, exp_done);
        check(got_min === exp_min, {name, " min_data"}, int'(got_min), int'(exp_min));
        bad_idx = -1;
        for (int i = 0; i < got_busy.size(); i++)
            if (bad_idx < 0 && got_busy[i] !== ((i + 1) <= exp_done)) bad_idx = i + 1;
        check(bad_idx < 0, {name, " busy_window_cycle"}, bad_idx, 0);
    endtask

    initial begin
        Rst_N = 1'b0; Start = 1'b0; Base_Addr = '0; Length = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);

        vecs[0] = '{"t1_basic", 8'h00, 4, '{5, 3, 7, 3, 0, 0, 0, 0}, 8'b0000_0011, 8'd3, 6};
        vecs[1] = '{"t2_wrap", 8'hFE, 4, '{9, 9, 2, 9, 0, 0, 0, 0}, 8'b0000_0101, 8'd2, 6};
        vecs[2] = '{"t3_len0", 8'h10, 0, '{0, 0, 0, 0, 0, 0, 0, 0}, 8'b0000_0000, 8'hFF, 1};
        vecs[3] = '{"t4_ties", 8'h30, 3, '{8'h40, 8'h40, 8'h40, 0, 0, 0, 0, 0}, 8'b0000_0001, 8'h40, 5};
        vecs[4] = '{"t_allones", 8'h80, 2, '{8'hFF, 8'hFF, 0, 0, 0, 0, 0, 0}, 8'b0000_0001, 8'hFF, 4};

        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check(Busy === 1'b0, "reset busy", Busy, 0);
        check(Done === 1'b0, "reset done", Done, 0);
        check(Mem_Rd_En === 1'b0, "reset rd_en", Mem_Rd_En, 0);
        check(Load_Addr === 1'b0, "reset load_addr", Load_Addr, 0);
        check(Min_Data === 8'hFF, "reset min_data", Min_Data, 8'hFF);
        Rst_N = 1'b1;

        foreach (vecs[v]) begin
            for (int i = 0; i < vecs[v].len; i++) mem[8'(int'(vecs[v].base) + i)] = vecs[v].words[i];
            exp_rd.delete();
            exp_ld.delete();
            for (int i = 0; i < vecs[v].len; i++) begin
                exp_rd.push_back(8'(int'(vecs[v].base) + i));
                if (vecs[v].load_mask[i]) exp_ld.push_back(8'(int'(vecs[v].base) + i));
            end
            exp_min  = vecs[v].min_val;
            exp_done = vecs[v].done_cyc;
            run(vecs[v].base, vecs[v].len, 0);
            compare(vecs[v].name);
        end

        // Start re-pulsed in cycle 2 of a 5-word search, and during the DONE cycle of another.
        for (int i = 0; i < 5; i++) mem[8'h50 + i] = 8'(60 - i * 7);
        model(8'h50, 5);
        run(8'h50, 5, 2);
        compare("t5_restart_busy");
        model(8'h60, 2);
        run(8'h60, 2, 4);
        compare("t5_restart_done");

        // Reset asserted during cycle 3 of an 8-word search.
        @(negedge Clk);
        Base_Addr = 8'h20; Length = 9'd8; Start = 1'b1;
        @(posedge Clk);
        #1 Start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        @(negedge Clk);
        Rst_N = 1'b0;
        @(negedge Clk);
        check(Busy === 1'b0, "t6 busy_after_reset", Busy, 0);
        check(Mem_Rd_En === 1'b0, "t6 rd_en_after_reset", Mem_Rd_En, 0);
        check(Min_Data === 8'hFF, "t6 min_after_reset", Min_Data, 8'hFF);
        check(Load_Addr === 1'b0, "t6 load_after_reset", Load_Addr, 0);
        Rst_N = 1'b1;
        begin
            int seen_done;
            seen_done = 0;
            for (int c = 0; c < 12; c++) begin
                @(negedge Clk);
                if (Done) seen_done++;
            end
            check(seen_done == 0, "t6 no_done_after_reset", seen_done, 0);
        end
        model(8'h20, 8);
        run(8'h20, 8, 0);
        compare("t6_rerun");

        // Randomized windows, including narrow data ranges to force ties.
        for (int r = 0; r < 20; r++) begin
            logic [7:0] b;
            int l;
            int span;
            b = 8'($urandom_range(0, 255));
            l = $urandom_range(0, 20);
            span = (r % 2 == 0) ? 4 : 255;
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, span));
            model(b, l);
            run(b, l, 0);
            compare($sformatf("rand%0d", r));
        end

        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(1, 255));
        mem[8'h33] = 8'h00;
        model(8'hC0, 256);
        run(8'hC0, 256, 0);
        compare("full_window");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
